// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce filter, and
// press/release pulse generation with optional auto-repeat while held.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic held
);

    // state  | meaning
    // IDLE   | button released, waiting for a debounced rise
    // DELAY  | pressed, counting towards the first repeat
    // REPEAT | held past the delay, emitting periodic repeats
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] dcnt;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_next;
    logic             held_next;
    logic             press_next;
    logic             release_next;
    logic             rise;
    logic             fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            dcnt   <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            if (sync2 == stable) begin
                dcnt <= '0;
            end else if (dcnt == DB_LAST) begin
                stable <= ~stable;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + CNT_W'(1);
            end
        end
    end

    // btn_level lags stable by one cycle, so a mismatch marks the edge
    // that the registered outputs are about to show.
    assign rise = stable & ~btn_level;
    assign fall = ~stable & btn_level;

    always_comb begin
        state_next   = state;
        rcnt_next    = rcnt;
        held_next    = held;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (fall) begin
            release_next = 1'b1;
            held_next    = 1'b0;
            rcnt_next    = '0;
            state_next   = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        press_next = 1'b1;
                        rcnt_next  = '0;
                        state_next = DELAY;
                    end
                end
                DELAY: begin
                    if (rcnt == RD_LAST) begin
                        held_next  = 1'b1;
                        rcnt_next  = '0;
                        state_next = REPEAT;
                        press_next = REPEAT_EN;
                    end else begin
                        rcnt_next = rcnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (rcnt == RP_LAST) begin
                        rcnt_next  = '0;
                        press_next = REPEAT_EN;
                    end else begin
                        rcnt_next = rcnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                    held_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rcnt        <= '0;
            held        <= 1'b0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_next;
            rcnt        <= rcnt_next;
            held        <= held_next;
            btn_level   <= stable;
            btn_press   <= press_next;
            btn_release <= release_next;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios then random button
// activity, checked cycle by cycle against a timing-rule reference model.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level, btn_press, btn_release, held;
    logic btn_level0, btn_press0, btn_release0, held0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .REPEAT_EN(1'b1), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .held(held)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .REPEAT_EN(1'b0), .CNT_W(8)
    ) dut0 (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(btn_level0), .btn_press(btn_press0),
        .btn_release(btn_release0), .held(held0)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int cnt_press  = 0;
    int cnt_press0 = 0;

    // Reference model: synchronised samples, a window of the last D
    // samples for debounce, and time-since-rise arithmetic for repeats.
    bit m_s1, m_s2, m_stable;
    bit vq[$];
    int edge_n = 0;
    int rise_t = 0;
    bit e_level, e_press, e_press0, e_release, e_held;

    task automatic model_edge(input bit r, input bit b);
        bit v, new_level, prev_level, all_diff;
        int s;
        edge_n++;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0;
            vq.delete();
            e_level = 0; e_press = 0; e_press0 = 0; e_release = 0; e_held = 0;
            return;
        end
        prev_level = e_level;
        v = m_s2;
        m_s2 = m_s1;
        m_s1 = b;
        vq.push_back(v);
        if (vq.size() > D) void'(vq.pop_front());
        new_level = m_stable;
        all_diff = (vq.size() == D);
        foreach (vq[i]) if (vq[i] == m_stable) all_diff = 0;
        if (all_diff) m_stable = !m_stable;

        e_level = new_level;
        e_press = 0; e_press0 = 0; e_release = 0;
        if (new_level && !prev_level) begin
            rise_t = edge_n;
            e_press = 1; e_press0 = 1; e_held = 0;
        end else if (!new_level && prev_level) begin
            e_release = 1; e_held = 0;
        end else if (new_level) begin
            s = edge_n - rise_t;
            e_held  = (s >= RD);
            e_press = (s >= RD) && (((s - RD) % RP) == 0);
        end else begin
            e_held = 0;
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    endtask

    task automatic tick(input logic r, input logic b);
        rst = r;
        btn_in = b;
        @(posedge clk);
        model_edge(r, b);
        @(negedge clk);
        cyc++;
        check_bit("btn_level",    btn_level,    e_level);
        check_bit("btn_press",    btn_press,    e_press);
        check_bit("btn_release",  btn_release,  e_release);
        check_bit("held",         held,         e_held);
        check_bit("btn_level0",   btn_level0,   e_level);
        check_bit("btn_press0",   btn_press0,   e_press0);
        check_bit("btn_release0", btn_release0, e_release);
        check_bit("held0",        held0,        e_held);
        if (btn_press)  cnt_press++;
        if (btn_press0) cnt_press0++;
    endtask

    task automatic run(input logic r, input logic b, input int n);
        for (int i = 0; i < n; i++) tick(r, b);
    endtask

    initial begin
        int lvl, len;

        // reset with the pin toggling, then quiet
        tick(1, 0); tick(1, 1); tick(1, 0);
        run(0, 0, 5);

        // clean press and release
        run(0, 1, 12);
        run(0, 0, 15);

        // bounce shorter than the debounce window
        cnt_press = 0;
        run(0, 1, 3); run(0, 0, 2); run(0, 1, 2); run(0, 0, 15);
        check_int("bounce_presses", cnt_press, 0);

        // auto-repeat over 50 held cycles
        cnt_press = 0; cnt_press0 = 0;
        run(0, 1, 50);
        run(0, 0, 15);
        check_int("repeat_presses", cnt_press, 5);
        check_int("norepeat_presses", cnt_press0, 1);

        // release during DELAY
        run(0, 1, 16); run(0, 0, 15);
        // fall exactly on the first repeat slot, then on a later one
        run(0, 1, 20); run(0, 0, 15);
        run(0, 1, 28); run(0, 0, 15);

        // reset while held, pin stays high
        run(0, 1, 31);
        run(1, 1, 2);
        cnt_press = 0;
        run(0, 1, 6);
        check_int("press_after_reset", cnt_press, 0);
        run(0, 1, 1);
        check_int("press_after_reset_edge", cnt_press, 1);
        run(0, 1, 30);
        run(0, 0, 15);

        // random activity with occasional resets
        for (int seg = 0; seg < 40; seg++) begin
            lvl = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            if ($urandom_range(0, 19) == 0) run(1, lvl[0], int'($urandom_range(1, 3)));
            run(0, lvl[0], len);
        end
        run(0, 0, 15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
